// File: rtl/haze_pkg.sv
// Shared types for the haze-removal pipeline: pixel width, RGB triple and
// the atmospheric-light estimator FSM states.
package haze_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t r;
    pixel_t g;
    pixel_t b;
  } rgb_t;

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} atm_state_t;

  function automatic pixel_t pix_min(input pixel_t a, input pixel_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/atm_max_reg.sv
// Compare-and-hold register: keeps the largest key seen and its RGB.
// Also exposes the would-be next contents so a final beat can be folded in.
module atm_max_reg
  import haze_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   update,
  input  pixel_t key,
  input  rgb_t   rgb,
  output pixel_t max_key,
  output rgb_t   max_rgb,
  output pixel_t nxt_key,
  output rgb_t   nxt_rgb
);

  // Strictly greater replaces, so on ties the earliest pixel is kept.
  always_comb begin
    nxt_key = max_key;
    nxt_rgb = max_rgb;
    if (load || (update && (key > max_key))) begin
      nxt_key = key;
      nxt_rgb = rgb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_key <= '0;
      max_rgb <= '0;
    end else begin
      max_key <= nxt_key;
      max_rgb <= nxt_rgb;
    end
  end

endmodule

// File: rtl/atmospheric_light_estimator.sv
// Streams one frame of {dark, R, G, B} beats and returns the RGB of the
// brightest dark-channel pixel as atmospheric light. Optional per-channel
// ceiling on the result when ATM_LIGHT_CLAMP_EN is defined.
module atmospheric_light_estimator
  import haze_pkg::*;
#(
  parameter int     CNT_W = 20,
  parameter pixel_t A_MAX = 8'd230
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic             in_eof,
  input  pixel_t           in_dark,
  input  pixel_t           in_r,
  input  pixel_t           in_g,
  input  pixel_t           in_b,
  output logic             a_valid,
  input  logic             a_ready,
  output pixel_t           a_r,
  output pixel_t           a_g,
  output pixel_t           a_b,
  output pixel_t           a_dark,
  output logic [CNT_W-1:0] a_count
);

  atm_state_t       state, state_nxt;
  logic             accept, start, fold, done;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  pixel_t           max_key, nxt_key;
  rgb_t             max_rgb, nxt_rgb, res_rgb;

  assign accept = in_valid & in_ready;
  assign start  = accept & in_sof;
  assign fold   = accept & ~in_sof & (state == ACCUM);
  assign done   = (start | fold) & in_eof;

  assign cnt_nxt = start ? CNT_W'(1)
                 : fold  ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1)
                 : cnt_q;

  atm_max_reg u_max (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .update  (fold),
    .key     (in_dark),
    .rgb     ('{r: in_r, g: in_g, b: in_b}),
    .max_key (max_key),
    .max_rgb (max_rgb),
    .nxt_key (nxt_key),
    .nxt_rgb (nxt_rgb)
  );

`ifdef ATM_LIGHT_CLAMP_EN
  assign res_rgb = '{r: pix_min(nxt_rgb.r, A_MAX),
                     g: pix_min(nxt_rgb.g, A_MAX),
                     b: pix_min(nxt_rgb.b, A_MAX)};
`else
  logic unused_a_max;
  assign unused_a_max = ^A_MAX;
  assign res_rgb = nxt_rgb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = in_eof ? RESULT : ACCUM;
      ACCUM:   if (done) state_nxt = RESULT;
      RESULT:  if (a_valid && a_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state so neither
  // depends combinationally on the input or result handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
      a_valid  <= 1'b0;
      cnt_q    <= '0;
      a_r      <= '0;
      a_g      <= '0;
      a_b      <= '0;
      a_dark   <= '0;
      a_count  <= '0;
    end else begin
      in_ready <= (state_nxt != RESULT);
      a_valid  <= (state_nxt == RESULT);
      cnt_q    <= cnt_nxt;
      if (done) begin
        a_r     <= res_rgb.r;
        a_g     <= res_rgb.g;
        a_b     <= res_rgb.b;
        a_dark  <= nxt_key;
        a_count <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_atmospheric_light_estimator.sv
// Self-checking bench for atmospheric_light_estimator: directed scenarios
// plus randomized frames compared against a frame-level reference model.
module tb_atmospheric_light_estimator;
  import haze_pkg::*;

  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_sof, in_eof;
  pixel_t           in_dark, in_r, in_g, in_b;
  logic             a_valid, a_ready;
  pixel_t           a_r, a_g, a_b, a_dark;
  logic [CNT_W-1:0] a_count;

  typedef struct {
    bit sof;
    bit eof;
    int dark;
    int r;
    int g;
    int b;
  } beat_t;

  beat_t frame_q[$];
  bit    active;
  int    exp_r, exp_g, exp_b, exp_dark, exp_cnt;
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  atmospheric_light_estimator #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .in_eof   (in_eof),
    .in_dark  (in_dark),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_r      (a_r),
    .a_g      (a_g),
    .a_b      (a_b),
    .a_dark   (a_dark),
    .a_count  (a_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampPix(input int v);
`ifdef ATM_LIGHT_CLAMP_EN
    return (v > 230) ? 230 : v;
`else
    return v;
`endif
  endfunction

  // Frame-level model: collect the beats of the live frame, pick the first
  // maximum when the frame closes.
  task automatic modelBeat(input beat_t bt);
    int best;
    if (bt.sof) begin
      frame_q.delete();
      active = 1'b1;
    end
    if (!active) return;
    frame_q.push_back(bt);
    if (bt.eof) begin
      best = 0;
      for (int i = 1; i < frame_q.size(); i++)
        if (frame_q[i].dark > frame_q[best].dark) best = i;
      exp_dark = frame_q[best].dark;
      exp_r    = clampPix(frame_q[best].r);
      exp_g    = clampPix(frame_q[best].g);
      exp_b    = clampPix(frame_q[best].b);
      exp_cnt  = (frame_q.size() > (2**CNT_W - 1)) ? (2**CNT_W - 1) : frame_q.size();
      active   = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit sof, input bit eof, input int dark,
                               input int r, input int g, input int b);
    int    n;
    beat_t bt;
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_eof   = eof;
    in_dark  = dark[7:0];
    in_r     = r[7:0];
    in_g     = g[7:0];
    in_b     = b[7:0];
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checkOutput("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    bt = '{sof: sof, eof: eof, dark: dark, r: r, g: g, b: b};
    modelBeat(bt);
    #1 in_valid = 1'b0;
  endtask

  task automatic collectResult(input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checkOutput("a_valid_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("a_dark", a_dark, exp_dark);
    checkOutput("a_r", a_r, exp_r);
    checkOutput("a_g", a_g, exp_g);
    checkOutput("a_b", a_b, exp_b);
    checkOutput("a_count", a_count, exp_cnt);
    checkOutput("in_ready_in_result", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_a_valid", a_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_a_dark", a_dark, exp_dark);
      checkOutput("hold_a_rgb", {8'd0, a_r, a_g, a_b}, {8'd0, exp_r[7:0], exp_g[7:0], exp_b[7:0]});
    end
    a_ready = 1'b1;
    @(posedge clk);
    #1 a_ready = 1'b0;
    checkOutput("a_valid_drop", a_valid, 0);
    checkOutput("in_ready_back", in_ready, 1);
    checkOutput("a_dark_after", a_dark, exp_dark);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_a_valid"}, a_valid, 0);
    checkOutput({tag, "_a_rgb"}, {8'd0, a_r, a_g, a_b}, 0);
    checkOutput({tag, "_a_dark"}, a_dark, 0);
    checkOutput({tag, "_a_count"}, a_count, 0);
  endtask

  initial begin
    int len, rs;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    in_dark = '0; in_r = '0; in_g = '0; in_b = '0; a_ready = 1'b0;
    active = 1'b0;
    #12;
    checkResetState("reset");
    @(negedge clk) rst = 1'b0;

    $display("[TB] basic frame with back-pressure");
    applyStimulus(1, 0, 10, 5, 6, 7);
    applyStimulus(0, 0, 200, 250, 240, 230);
    checkOutput("no_early_valid", a_valid, 0);
    applyStimulus(0, 1, 50, 1, 2, 3);
    checkOutput("latency_a_valid", a_valid, 1);
    checkOutput("latency_in_ready", in_ready, 0);
    collectResult(5);

    $display("[TB] tie keeps earliest");
    applyStimulus(1, 0, 90, 1, 2, 3);
    applyStimulus(0, 1, 90, 7, 8, 9);
    collectResult(0);

    $display("[TB] single-pixel frame");
    applyStimulus(1, 1, 5, 9, 9, 9);
    checkOutput("single_a_valid", a_valid, 1);
    collectResult(1);

    $display("[TB] restart on mid-frame sof");
    applyStimulus(1, 0, 250, 100, 100, 100);
    applyStimulus(1, 1, 3, 4, 5, 6);
    collectResult(0);

    $display("[TB] async reset mid-frame");
    applyStimulus(1, 0, 100, 11, 12, 13);
    applyStimulus(0, 0, 120, 21, 22, 23);
    #3 rst = 1'b1;
    frame_q.delete();
    active = 1'b0;
    #1;
    checkResetState("midreset");
    @(negedge clk) rst = 1'b0;
    applyStimulus(0, 0, 200, 1, 1, 1);
    applyStimulus(0, 1, 210, 2, 2, 2);
    repeat (4) begin
      @(negedge clk);
      checkOutput("dropped_no_valid", a_valid, 0);
    end
    applyStimulus(1, 0, 40, 31, 32, 33);
    applyStimulus(0, 1, 41, 241, 242, 243);
    collectResult(0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0)
        applyStimulus(0, $urandom_range(0, 1), $urandom_range(0, 255), 0, 0, 0);
      len = $urandom_range(1, 12);
      rs  = (len > 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : -1;
      for (int i = 0; i < len; i++)
        applyStimulus(i == 0 || i == rs, i == len - 1,
                      (f % 2) ? $urandom_range(0, 7) : $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      collectResult($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
